// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter sharing the single spell memory port between the spell
// core sequencer (port A) and the Wishbone debug path (port B). Each grant is
// held until the memory completes or the Busy timeout expires. Completion is
// returned to the grantee as a one-cycle ack carrying the read data.
module spell_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    // port A: spell core fetch/store sequencer
    input  logic       a_select,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_data_in,
    input  logic [1:0] a_type,
    input  logic       a_write,
    output logic       a_ack,
    output logic       a_error,
    output logic [7:0] a_data_out,
    // port B: Wishbone host debug path
    input  logic       b_select,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_data_in,
    input  logic [1:0] b_type,
    input  logic       b_write,
    output logic       b_ack,
    output logic       b_error,
    output logic [7:0] b_data_out,
    // spell memory
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic [1:0] mem_type,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    // status
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // A zero TIMEOUT_CYCLES disables the timeout, so the compare value is
    // irrelevant in that case and is clamped to keep it in range.
    localparam logic       TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_d;
    logic [7:0] counter, counter_d;
    logic       grant_b;
    logic       done;
    logic       timeout_hit;

    logic       mem_select_d, mem_write_d;
    logic [7:0] mem_addr_d, mem_data_in_d;
    logic [1:0] mem_type_d;
    logic       a_ack_d, a_error_d, b_ack_d, b_error_d;
    logic [7:0] a_data_out_d, b_data_out_d;
    logic       busy_d, owner_d;

    // Next-state and next-output logic for every registered output.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d       = state;
        counter_d     = counter;
        mem_select_d  = mem_select;
        mem_addr_d    = mem_addr;
        mem_data_in_d = mem_data_in;
        mem_type_d    = mem_type;
        mem_write_d   = mem_write;
        a_ack_d       = a_ack;
        a_error_d     = a_error;
        a_data_out_d  = a_data_out;
        b_ack_d       = b_ack;
        b_error_d     = b_error;
        b_data_out_d  = b_data_out;
        owner_d       = owner;
        // On a tie the port that did not own the memory last wins.
        grant_b       = b_select && !(a_select && owner);
        timeout_hit   = TIMEOUT_EN && (counter == TIMEOUT_LAST);
        done          = mem_data_ready || timeout_hit;

        case (state)
            IDLE: begin
                if (a_select || b_select) begin
                    mem_select_d  = 1'b1;
                    mem_addr_d    = grant_b ? b_addr    : a_addr;
                    mem_data_in_d = grant_b ? b_data_in : a_data_in;
                    mem_type_d    = grant_b ? b_type    : a_type;
                    mem_write_d   = grant_b ? b_write   : a_write;
                    owner_d       = grant_b;
                    counter_d     = 8'd0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    // Real data beats a coincident timeout.
                    mem_select_d = 1'b0;
                    mem_write_d  = 1'b0;
                    if (owner) begin
                        b_ack_d      = 1'b1;
                        b_error_d    = !mem_data_ready;
                        b_data_out_d = mem_data_ready ? mem_data_out : 8'd0;
                    end else begin
                        a_ack_d      = 1'b1;
                        a_error_d    = !mem_data_ready;
                        a_data_out_d = mem_data_ready ? mem_data_out : 8'd0;
                    end
                    state_d = RELEASE;
                end else if (counter != 8'hFF) begin
                    counter_d = counter + 8'd1;
                end
            end
            RELEASE: begin
                // One dead cycle lets the requester drop its select before
                // the next arbitration, so a stale select is never re-granted.
                a_ack_d   = 1'b0;
                a_error_d = 1'b0;
                b_ack_d   = 1'b0;
                b_error_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset wins over every other event.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (reset) begin
            state       <= IDLE;
            counter     <= 8'd0;
            mem_select  <= 1'b0;
            mem_addr    <= 8'd0;
            mem_data_in <= 8'd0;
            mem_type    <= 2'd0;
            mem_write   <= 1'b0;
            a_ack       <= 1'b0;
            a_error     <= 1'b0;
            a_data_out  <= 8'd0;
            b_ack       <= 1'b0;
            b_error     <= 1'b0;
            b_data_out  <= 8'd0;
            busy        <= 1'b0;
            owner       <= 1'b1;
        end else begin
            state       <= state_d;
            counter     <= counter_d;
            mem_select  <= mem_select_d;
            mem_addr    <= mem_addr_d;
            mem_data_in <= mem_data_in_d;
            mem_type    <= mem_type_d;
            mem_write   <= mem_write_d;
            a_ack       <= a_ack_d;
            a_error     <= a_error_d;
            a_data_out  <= a_data_out_d;
            b_ack       <= b_ack_d;
            b_error     <= b_error_d;
            b_data_out  <= b_data_out_d;
            busy        <= busy_d;
            owner       <= owner_d;
        end
    end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Self-checking bench for spell_mem_arbiter: a vector table run through a
// scoreboard, plus hand-written round-robin, reset, drop and no-timeout cases.
module tb_spell_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance, TIMEOUT_CYCLES = 4
    logic       reset;
    logic       a_select, a_write, b_select, b_write;
    logic [7:0] a_addr, a_data_in, b_addr, b_data_in;
    logic [1:0] a_type, b_type;
    logic       a_ack, a_error, b_ack, b_error;
    logic [7:0] a_data_out, b_data_out;
    logic       mem_select, mem_write, mem_data_ready;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic [1:0] mem_type;
    logic       busy, owner;

    // second instance with the timeout disabled
    logic       z_a_select;
    logic       z_zero1;
    logic [7:0] z_zero8;
    logic [1:0] z_zero2;
    logic       z_a_ack, z_a_error, z_b_ack, z_b_error;
    logic [7:0] z_a_data_out, z_b_data_out;
    logic       z_mem_select, z_mem_write;
    logic [7:0] z_mem_addr, z_mem_data_in;
    logic [1:0] z_mem_type;
    logic       z_busy, z_owner;

    spell_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .a_select(a_select), .a_addr(a_addr), .a_data_in(a_data_in), .a_type(a_type),
        .a_write(a_write), .a_ack(a_ack), .a_error(a_error), .a_data_out(a_data_out),
        .b_select(b_select), .b_addr(b_addr), .b_data_in(b_data_in), .b_type(b_type),
        .b_write(b_write), .b_ack(b_ack), .b_error(b_error), .b_data_out(b_data_out),
        .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_type(mem_type), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .mem_data_ready(mem_data_ready), .busy(busy), .owner(owner)
    );

    spell_mem_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset),
        .a_select(z_a_select), .a_addr(8'h66), .a_data_in(z_zero8), .a_type(z_zero2),
        .a_write(z_zero1), .a_ack(z_a_ack), .a_error(z_a_error), .a_data_out(z_a_data_out),
        .b_select(z_zero1), .b_addr(z_zero8), .b_data_in(z_zero8), .b_type(z_zero2),
        .b_write(z_zero1), .b_ack(z_b_ack), .b_error(z_b_error), .b_data_out(z_b_data_out),
        .mem_select(z_mem_select), .mem_addr(z_mem_addr), .mem_data_in(z_mem_data_in),
        .mem_type(z_mem_type), .mem_write(z_mem_write), .mem_data_out(z_zero8),
        .mem_data_ready(z_zero1), .busy(z_busy), .owner(z_owner)
    );

    typedef struct {
        logic       port;       // 0=A, 1=B
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] mtype;
        logic       write;
        int         latency;    // Busy cycles before data_ready; large = never
        logic [7:0] resp;
        logic       exp_error;
        logic [7:0] exp_data;
        int         exp_cycles; // cycles mem_select stays high
    } vec_t;

    typedef struct {
        logic       port;
        logic       error;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] other_dout;
        exp_t       e;
        bit         got;
        int         sel_cycles;
        other_dout = v.port ? a_data_out : b_data_out;
        if (v.port) begin
            b_select = 1'b1; b_addr = v.addr; b_data_in = v.wdata; b_type = v.mtype; b_write = v.write;
        end else begin
            a_select = 1'b1; a_addr = v.addr; a_data_in = v.wdata; a_type = v.mtype; a_write = v.write;
        end
        sb.push_back('{v.port, v.exp_error, v.exp_data});
        tick();
        check("grant mem_select", mem_select, 1);
        check("grant owner", owner, v.port);
        check("grant mem_addr", mem_addr, v.addr);
        check("grant mem_type", mem_type, v.mtype);
        check("grant mem_write", mem_write, v.write);
        check("grant busy", busy, 1);
        // requester changes during Busy must be ignored
        if (v.port) begin b_addr = ~v.addr; b_data_in = ~v.wdata; end
        else begin a_addr = ~v.addr; a_data_in = ~v.wdata; end
        got = 0;
        sel_cycles = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (mem_select) begin
                sel_cycles++;
                check("frozen mem_fields", {mem_addr, mem_data_in, 1'b0, mem_write},
                      {v.addr, v.wdata, 1'b0, v.write});
            end
            mem_data_ready = (k == v.latency);
            mem_data_out   = (k == v.latency) ? v.resp : 8'hEE;
            tick();
            mem_data_ready = 1'b0;
            check("idle port ack", v.port ? a_ack : b_ack, 0);
            if (a_ack || b_ack) begin
                got = 1;
                a_select = 1'b0;
                b_select = 1'b0;
            end
        end
        check("ack seen", got, 1);
        if (got) begin
            e = sb.pop_front();
            check("ack port", {a_ack, b_ack}, e.port ? 2'b01 : 2'b10);
            check("ack error", e.port ? b_error : a_error, e.error);
            check("ack data", e.port ? b_data_out : a_data_out, e.data);
            check("done mem_select/write", {mem_select, mem_write}, 2'b00);
            check("busy cycles", sel_cycles, v.exp_cycles);
        end else begin
            sb.delete();
        end
        tick();
        check("release ack/error", {a_ack, a_error, b_ack, b_error}, 4'b0000);
        check("release busy", busy, 0);
        check("data_out held", v.port ? b_data_out : a_data_out, v.exp_data);
        check("other data_out", v.port ? a_data_out : b_data_out, other_dout);
    endtask

    initial begin
        int   rises, acks;
        bit   gap_due;
        logic prev_sel;
        exp_t e;

        reset = 1'b1;
        a_select = 0; a_addr = 0; a_data_in = 0; a_type = 0; a_write = 0;
        b_select = 0; b_addr = 0; b_data_in = 0; b_type = 0; b_write = 0;
        mem_data_ready = 0; mem_data_out = 0;
        z_a_select = 0; z_zero1 = 0; z_zero8 = 0; z_zero2 = 0;

        vecs[0] = '{1'b0, 8'h10, 8'h00, 2'b00, 1'b0, 1,  8'h3F, 1'b0, 8'h3F, 2};
        vecs[1] = '{1'b1, 8'h05, 8'hA5, 2'b01, 1'b1, 2,  8'h5C, 1'b0, 8'h5C, 3};
        vecs[2] = '{1'b0, 8'h20, 8'h00, 2'b00, 1'b0, 99, 8'h00, 1'b1, 8'h00, 4};
        vecs[3] = '{1'b1, 8'h33, 8'h00, 2'b01, 1'b0, 3,  8'hC3, 1'b0, 8'hC3, 4};
        vecs[4] = '{1'b0, 8'hFF, 8'h0F, 2'b10, 1'b1, 0,  8'h77, 1'b0, 8'h77, 1};
        vecs[5] = '{1'b1, 8'h80, 8'h00, 2'b11, 1'b0, 1,  8'h81, 1'b0, 8'h81, 2};

        tick();
        tick();
        check("reset outputs", {busy, mem_select, mem_write, mem_addr, mem_data_in, mem_type,
                                a_ack, a_error, a_data_out, b_ack, b_error, b_data_out}, 0);
        check("reset owner", owner, 1);
        reset = 1'b0;

        // Both ports held high: grants must alternate A, B, A, B with gaps.
        a_select = 1; a_addr = 8'h11;
        b_select = 1; b_addr = 8'h22;
        sb.push_back('{1'b0, 1'b0, 8'h12});
        sb.push_back('{1'b1, 1'b0, 8'h23});
        sb.push_back('{1'b0, 1'b0, 8'h12});
        sb.push_back('{1'b1, 1'b0, 8'h23});
        rises = 0; acks = 0; gap_due = 0; prev_sel = 0;
        for (int k = 0; k < 60 && acks < 4; k++) begin
            mem_data_ready = mem_select;
            mem_data_out   = mem_addr + 8'd1;
            tick();
            mem_data_ready = 1'b0;
            if (gap_due) check("rr release gap", mem_select, 0);
            gap_due = 0;
            if (mem_select && !prev_sel) begin
                rises++;
                check("rr grant addr", mem_addr, owner ? 8'h22 : 8'h11);
            end
            prev_sel = mem_select;
            if (a_ack || b_ack) begin
                acks++;
                e = sb.pop_front();
                check("rr ack port", {a_ack, b_ack}, e.port ? 2'b01 : 2'b10);
                check("rr ack data", e.port ? b_data_out : a_data_out, e.data);
                check("rr mem_select at ack", mem_select, 0);
                gap_due = 1;
                if (acks == 4) begin a_select = 0; b_select = 0; end
            end
        end
        check("rr ack count", acks, 4);
        check("rr grant count", rises, 4);
        sb.delete();
        tick();
        tick();
        check("rr no stale grant", mem_select, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-Busy, coinciding with data_ready: reset must win.
        a_select = 1; a_addr = 8'h44; a_write = 0;
        tick();
        check("rst grant", mem_select, 1);
        tick();
        reset = 1; a_select = 0; mem_data_ready = 1; mem_data_out = 8'h99;
        tick();
        reset = 0; mem_data_ready = 0;
        check("rst outputs", {busy, mem_select, mem_write, mem_addr, mem_data_in, mem_type,
                              a_ack, a_error, a_data_out, b_ack, b_error, b_data_out}, 0);
        check("rst owner", owner, 1);
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_ack || b_ack || mem_select) acks++;
        end
        check("rst no ack/grant", acks, 0);

        // Requester drops select mid-Busy: access still completes, one ack.
        a_select = 1; a_addr = 8'h55;
        tick();
        check("drop grant", {mem_select, mem_addr}, {1'b1, 8'h55});
        a_select = 0;
        tick();
        tick();
        mem_data_ready = 1; mem_data_out = 8'h9A;
        tick();
        mem_data_ready = 0;
        check("drop ack", {a_ack, a_error, a_data_out}, {1'b1, 1'b0, 8'h9A});
        acks = 0; rises = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_ack) acks++;
            if (mem_select) rises++;
        end
        check("drop single ack", acks, 0);
        check("drop no regrant", rises, 0);

        // Timeout disabled: a never-ready memory must hold the grant forever.
        z_a_select = 1;
        tick();
        check("no-timeout grant", z_mem_select, 1);
        acks = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (z_a_ack || z_b_ack) acks++;
        end
        check("no-timeout acks", acks, 0);
        check("no-timeout still busy", {z_busy, z_mem_select}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spell_mem_arbiter.md
Name: spell_mem_arbiter

Overview:
Shares the single spell memory port (select/addr/data_in/memory_type/write -> data_out/data_ready) between two requesters: port A (the spell core's fetch/store sequencer) and port B (the Wishbone host debug path for code/data upload and inspection). Grants are round-robin, and each grant holds until the memory completes or a timeout fires. Completion is returned as a one-cycle ack carrying the read data. The block sits between the spell core and the spell memory instance.

Parameters:
TIMEOUT_CYCLES, 255, maximum Busy cycles before a forced error completion; 0 disables the timeout; legal range 0..255.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
a_select  input  1  port A request; held high until a_ack is seen
a_addr  input  8  port A address
a_data_in  input  8  port A write data
a_type  input  2  port A memory type (code/data encoding, passed through unchanged)
a_write  input  1  port A write enable
a_ack  output  1  one-cycle completion pulse to port A
a_error  output  1  qualifies a_ack: 1 means the transaction timed out
a_data_out  output  8  read data to port A, valid while a_ack=1
b_select, b_addr, b_data_in, b_type, b_write, b_ack, b_error, b_data_out  same as port A, for port B
mem_select  output  1  to memory: select
mem_addr  output  8  to memory: address
mem_data_in  output  8  to memory: write data
mem_type  output  2  to memory: memory type
mem_write  output  1  to memory: write enable
mem_data_out  input  8  from memory: read data
mem_data_ready  input  1  from memory: completion
busy  output  1  1 when state is not Idle
owner  output  1  last or current grantee (0=A, 1=B)

Behaviour:
- All outputs are registered. On reset: state=Idle; every output 0; owner=1, so A wins the first tie; timeout counter=0.
- States: Idle, Busy, Release.
- Idle, no request: hold; mem_select=0.
- Idle, exactly one select high: grant that port.
- Idle, both selects high: grant the port != owner (round-robin).
- On grant, at the same edge: latch the grantee's addr/data_in/type/write into the mem_* outputs; mem_select<=1; owner<=grantee; counter<=0; state<=Busy. Grant latency is 1 cycle from select high to mem_select high.
- mem_* fields stay frozen for the whole of Busy. Requester input changes during Busy are ignored.
- Busy, mem_data_ready=1:
  - mem_select<=0; mem_write<=0.
  - The grantee's data_out<=mem_data_out; ack<=1; error<=0.
  - state<=Release.
- Busy, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no data_ready:
  - Same as completion, but data_out<=0 and error<=1.
  - If data_ready and the timeout coincide, the normal completion wins (error=0).
- Busy, otherwise: counter increments (8-bit, saturating).
- Release lasts exactly 1 cycle: ack<=0, error<=0, state<=Idle. data_out holds its value until the next ack to that port.
- Requester contract: drop select at the same clock edge that samples ack=1. Release then guarantees a stale select is never re-granted.
- Minimum turnaround is 3 cycles per transaction (grant, memory response at its earliest, release). Back-to-back requests from both ports alternate A, B, A, B.
- A requester that drops select mid-Busy does not abort the transaction. The memory access completes and the ack pulse is still issued; the requester ignores it.
- The non-granted port's ack, error and data_out never change during another port's transaction.
- Synchronous reset asserted mid-Busy: next cycle state=Idle, mem_select=0, no ack is issued, and the pending request is lost.
- Reset takes precedence over every other event in the same cycle.

Test Plan:
- Single A read: a_select=1, addr=0x10, type=code, memory returns 0x3F after 2 cycles -> mem_addr=0x10 and mem_select=1 one cycle after request; a_ack=1 for exactly 1 cycle with a_data_out=0x3F, a_error=0; b_ack stays 0.
- Simultaneous: A and B select together right after reset -> A granted first, then B; with both held continuously, the grant order is A, B, A, B; no two mem_select windows are adjacent (at least 1 cycle of mem_select=0 between them).
- B write: b_write=1, addr=0x05, data=0xA5, type=data -> mem_write=1, mem_data_in=0xA5 throughout Busy; b_ack pulses after mem_data_ready; mem_write returns to 0.
- Timeout with TIMEOUT_CYCLES=4 and memory never ready -> mem_select falls after 4 Busy cycles; a_ack=1, a_error=1, a_data_out=0. Repeat with TIMEOUT_CYCLES=0 -> no ack after 1000 cycles.
- Coincidence: data_ready arrives on the exact timeout cycle -> ack with error=0 and the memory's data.
- Reset mid-Busy, then an A request whose select drops mid-transaction -> after reset: busy=0, all outputs 0, no ack; for the dropped request, the transaction still completes and a_ack pulses once, with no re-grant.
